fma_align_seq: RTL and testbench
================================

FMA_ALIGN_SEQ -- requirements
Module: fma_align_seq

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 8, maximum right-shift bits applied per cycle (legal 1..48).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports exp_P, exp_C  input  8 each  product and addend biased exponents.
REQ-007 SHALL have ports man_P  input  48  product mantissa; man_C  input  24  addend mantissa.
REQ-008 SHALL have port out_valid  output  1  aligned result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port sel  output  2  00 P larger, 01 C larger, 10 equal.
REQ-011 SHALL have port exp_max  output  8  larger exponent.
REQ-012 SHALL have ports man_big, man_small  output  48 each  unshifted and aligned mantissas.
REQ-013 SHALL have port sticky  output  1  OR of all bits shifted out of man_small.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CMP, SHIFT, DONE.
REQ-016 SHALL assert in_ready only in IDLE; capture inputs when in_valid && in_ready, then go to CMP.
REQ-017 SHALL extend the addend as man_C_ext = {man_C, 24'b0}.
REQ-018 CMP SHALL set sel, exp_max and diff = |exp_P - exp_C| (8-bit unsigned, no wrap); sel=10 when exponents are equal.
REQ-019 CMP SHALL load man_big with the larger-exponent operand and man_small with the other; when sel=10, man_big=man_P and man_small=man_C_ext.
REQ-020 CMP SHALL clamp the remaining shift count to min(diff, 48).
REQ-021 CMP SHALL clear sticky.
REQ-022 CMP SHALL go to DONE if the remaining count is 0, otherwise to SHIFT.
REQ-023 SHIFT SHALL right-shift man_small by k = min(remaining, SHIFT_STEP) each cycle.
REQ-024 SHIFT SHALL OR the k shifted-out bits into sticky and reduce remaining by k.
REQ-025 SHIFT SHALL go to DONE in the cycle remaining reaches 0.
REQ-026 Latency SHALL be out_valid high exactly 2 + ceil(min(diff,48)/SHIFT_STEP) cycles after the accept edge.
REQ-027 DONE SHALL hold out_valid high with sel, exp_max, man_big, man_small and sticky stable until out_ready is sampled high.
REQ-028 DONE SHALL return to IDLE on the out_ready edge; in_ready SHALL be high the next cycle (no same-cycle accept).
REQ-029 For any diff of 48 or more, man_small SHALL be 0 and sticky SHALL equal the OR of the pre-shift small mantissa.
REQ-030 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and set in_ready=0, out_valid=0, busy=0, sel=00, exp_max=0, man_big=0, man_small=0, sticky=0.
REQ-032 in_ready SHALL rise in the first cycle after rst_n deasserts; reset in any state (including mid-SHIFT) SHALL discard the operation in progress.

Verification
REQ-033 exp_P=0x85, exp_C=0x80, man_P=48'h800000000000, man_C=24'h800000 -> sel=00, exp_max=0x85, man_small=48'h040000000000, sticky=0, out_valid at T+3.
REQ-034 exp_P=exp_C=0x7F -> sel=10, man_big=man_P, man_small={man_C,24'b0}, sticky=0, out_valid at T+2.
REQ-035 exp_C=0x90, exp_P=0x70, man_P=48'h000000000001 -> sel=01, man_big={man_C,24'b0}, man_small=0, sticky=1, out_valid at T+6.
REQ-036 exp_P=0xFF, exp_C=0x37 (diff 200), man_C=24'h000001 -> remaining clamped to 48, 6 SHIFT cycles, man_small=0, sticky=1, out_valid at T+8.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> all outputs stable and in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1.
REQ-038 Pulse rst_n low during SHIFT -> all outputs 0 asynchronously; after release, in_ready=1 and a new operand set completes correctly.

Source files
------------

// File: rtl/fma_align_seq.sv
// Exponent compare and mantissa alignment for an FMA datapath.
// Picks the larger-exponent operand, then right-shifts the other one
// by up to SHIFT_STEP bits per cycle, collecting shifted-out bits in sticky.
//
// state | meaning
// IDLE  | waiting for an operand set (in_ready high)
// CMP   | compare exponents, load big/small mantissas and clamped shift count
// SHIFT | align man_small, at most SHIFT_STEP bits per cycle
// DONE  | result held on the outputs until out_ready
module fma_align_seq #(
   parameter int SHIFT_STEP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  exp_P,
   input  logic [7:0]  exp_C,
   input  logic [47:0] man_P,
   input  logic [23:0] man_C,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  sel,
   output logic [7:0]  exp_max,
   output logic [47:0] man_big,
   output logic [47:0] man_small,
   output logic        sticky,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

   localparam logic [5:0] STEP    = 6'(SHIFT_STEP);
   localparam logic [5:0] MAX_SHF = 6'd48;

   state_t      state_q, state_d;
   logic        rdy_q, rdy_d;
   logic [7:0]  exp_p_q, exp_p_d;
   logic [7:0]  exp_c_q, exp_c_d;
   logic [47:0] man_p_q, man_p_d;
   logic [23:0] man_c_q, man_c_d;
   logic [5:0]  rem_q, rem_d;
   logic [1:0]  sel_q, sel_d;
   logic [7:0]  exp_max_q, exp_max_d;
   logic [47:0] man_big_q, man_big_d;
   logic [47:0] man_small_q, man_small_d;
   logic        sticky_q, sticky_d;

   logic [7:0]  diff;
   logic [5:0]  k;
   logic [47:0] out_mask;

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b0;
         exp_p_q     <= '0;
         exp_c_q     <= '0;
         man_p_q     <= '0;
         man_c_q     <= '0;
         rem_q       <= '0;
         sel_q       <= '0;
         exp_max_q   <= '0;
         man_big_q   <= '0;
         man_small_q <= '0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         exp_p_q     <= exp_p_d;
         exp_c_q     <= exp_c_d;
         man_p_q     <= man_p_d;
         man_c_q     <= man_c_d;
         rem_q       <= rem_d;
         sel_q       <= sel_d;
         exp_max_q   <= exp_max_d;
         man_big_q   <= man_big_d;
         man_small_q <= man_small_d;
         sticky_q    <= sticky_d;
      end
   end

   // Next-state and datapath updates for each FSM state.
   always_comb begin
      state_d     = state_q;
      exp_p_d     = exp_p_q;
      exp_c_d     = exp_c_q;
      man_p_d     = man_p_q;
      man_c_d     = man_c_q;
      rem_d       = rem_q;
      sel_d       = sel_q;
      exp_max_d   = exp_max_q;
      man_big_d   = man_big_q;
      man_small_d = man_small_q;
      sticky_d    = sticky_q;
      diff        = 8'd0;
      k           = (rem_q < STEP) ? rem_q : STEP;
      // a 48-bit shift by 48 yields zero, so the mask becomes all ones
      out_mask    = ~(48'hFFFF_FFFF_FFFF << k);

      case (state_q)
         IDLE: begin
            if (in_valid && rdy_q) begin
               exp_p_d = exp_P;
               exp_c_d = exp_C;
               man_p_d = man_P;
               man_c_d = man_C;
               state_d = CMP;
            end
         end
         CMP: begin
            if (exp_p_q > exp_c_q) begin
               sel_d       = 2'b00;
               diff        = exp_p_q - exp_c_q;
               exp_max_d   = exp_p_q;
               man_big_d   = man_p_q;
               man_small_d = {man_c_q, 24'b0};
            end else if (exp_c_q > exp_p_q) begin
               sel_d       = 2'b01;
               diff        = exp_c_q - exp_p_q;
               exp_max_d   = exp_c_q;
               man_big_d   = {man_c_q, 24'b0};
               man_small_d = man_p_q;
            end else begin
               sel_d       = 2'b10;
               exp_max_d   = exp_p_q;
               man_big_d   = man_p_q;
               man_small_d = {man_c_q, 24'b0};
            end
            rem_d    = (diff > 8'd48) ? MAX_SHF : diff[5:0];
            sticky_d = 1'b0;
            state_d  = (rem_d == 6'd0) ? DONE : SHIFT;
         end
         SHIFT: begin
            sticky_d    = sticky_q | (|(man_small_q & out_mask));
            man_small_d = man_small_q >> k;
            rem_d       = rem_q - k;
            if (rem_d == 6'd0) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      rdy_d = (state_d == IDLE);
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sel       = sel_q;
   assign exp_max   = exp_max_q;
   assign man_big   = man_big_q;
   assign man_small = man_small_q;
   assign sticky    = sticky_q;

endmodule

// File: tb/tb_fma_align_seq.sv
// Directed bench for fma_align_seq with hand-computed alignment results.
module tb_fma_align_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  exp_P = '0;
   logic [7:0]  exp_C = '0;
   logic [47:0] man_P = '0;
   logic [23:0] man_C = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [1:0]  sel;
   logic [7:0]  exp_max;
   logic [47:0] man_big;
   logic [47:0] man_small;
   logic        sticky;
   logic        busy;

   int total = 0;
   int bad   = 0;

   fma_align_seq #(.SHIFT_STEP(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .exp_P(exp_P), .exp_C(exp_C), .man_P(man_P), .man_C(man_C),
      .out_valid(out_valid), .out_ready(out_ready), .sel(sel),
      .exp_max(exp_max), .man_big(man_big), .man_small(man_small),
      .sticky(sticky), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".in_ready"}, 48'(in_ready), 48'd0);
      chk({tag, ".out_valid"}, 48'(out_valid), 48'd0);
      chk({tag, ".busy"}, 48'(busy), 48'd0);
      chk({tag, ".sel"}, 48'(sel), 48'd0);
      chk({tag, ".exp_max"}, 48'(exp_max), 48'd0);
      chk({tag, ".man_big"}, man_big, 48'd0);
      chk({tag, ".man_small"}, man_small, 48'd0);
      chk({tag, ".sticky"}, 48'(sticky), 48'd0);
   endtask

   // Present one operand set at a negedge and return the cycle count
   // (periods after the accept edge) at which out_valid is first seen.
   task automatic issue(input logic [7:0] ep, input logic [7:0] ec,
                        input logic [47:0] mp, input logic [23:0] mc,
                        output int lat);
      exp_P = ep; exp_C = ec; man_P = mp; man_C = mc;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_done(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".idle_in_ready"}, 48'(in_ready), 48'd1);
      chk({tag, ".idle_out_valid"}, 48'(out_valid), 48'd0);
      chk({tag, ".idle_busy"}, 48'(busy), 48'd0);
   endtask

   task automatic run_case(input string tag,
                           input logic [7:0] ep, input logic [7:0] ec,
                           input logic [47:0] mp, input logic [23:0] mc,
                           input int exp_lat, input logic [1:0] e_sel,
                           input logic [7:0] e_max, input logic [47:0] e_big,
                           input logic [47:0] e_small, input logic e_sticky);
      int lat;
      chk({tag, ".pre_in_ready"}, 48'(in_ready), 48'd1);
      issue(ep, ec, mp, mc, lat);
      chk({tag, ".latency"}, 48'(lat), 48'(exp_lat));
      chk({tag, ".sel"}, 48'(sel), 48'(e_sel));
      chk({tag, ".exp_max"}, 48'(exp_max), 48'(e_max));
      chk({tag, ".man_big"}, man_big, e_big);
      chk({tag, ".man_small"}, man_small, e_small);
      chk({tag, ".sticky"}, 48'(sticky), 48'(e_sticky));
      chk({tag, ".busy"}, 48'(busy), 48'd1);
   endtask

   initial begin
      int lat;

      // reset state, including the cycle right after release
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rel_in_ready", 48'(in_ready), 48'd0);
      @(negedge clk);
      chk("first_cycle_in_ready", 48'(in_ready), 48'd1);

      // P larger by 5: one shift cycle
      run_case("p_big", 8'h85, 8'h80, 48'h800000000000, 24'h800000,
               3, 2'b00, 8'h85, 48'h800000000000, 48'h040000000000, 1'b0);

      // hold in DONE for 5 cycles: outputs stable, no accept, in_valid ignored
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold.out_valid", 48'(out_valid), 48'd1);
         chk("hold.in_ready", 48'(in_ready), 48'd0);
         chk("hold.man_small", man_small, 48'h040000000000);
         chk("hold.man_big", man_big, 48'h800000000000);
         chk("hold.exp_max", 48'(exp_max), 48'h85);
      end
      in_valid = 1'b0;
      release_done("p_big");

      // equal exponents: no shift cycles
      run_case("equal", 8'h7F, 8'h7F, 48'hABCDEF012345, 24'h123456,
               2, 2'b10, 8'h7F, 48'hABCDEF012345, 48'h123456000000, 1'b0);
      release_done("equal");

      // C larger by 32: product shifted out entirely
      run_case("c_big", 8'h70, 8'h90, 48'h000000000001, 24'hC00000,
               6, 2'b01, 8'h90, 48'hC00000000000, 48'd0, 1'b1);
      release_done("c_big");

      // diff 200 clamps to 48 -> 6 shift cycles
      run_case("clamp", 8'hFF, 8'h37, 48'h800000000001, 24'h000001,
               8, 2'b00, 8'hFF, 48'h800000000001, 48'd0, 1'b1);
      release_done("clamp");

      // diff 11: partial last step (8 then 3), low bits 0x705 go to sticky
      run_case("partial", 8'h80, 8'h8B, 48'h000000000F05, 24'hA00000,
               4, 2'b01, 8'h8B, 48'hA00000000000, 48'h000000000001, 1'b1);
      release_done("partial");

      // out_ready while idle must not disturb anything
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_out_ready.in_ready", 48'(in_ready), 48'd1);

      // reset in the middle of SHIFT (diff 40 -> 5 shift cycles)
      exp_P = 8'h80; exp_C = 8'hA8; man_P = 48'hFFFFFFFFFFFF; man_C = 24'hFFFFFF;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midshift.busy", 48'(busy), 48'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midshift_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after_rst.in_ready", 48'(in_ready), 48'd1);
      chk("after_rst.out_valid", 48'(out_valid), 48'd0);

      // fresh operation completes normally after the abort
      run_case("after_rst", 8'h85, 8'h80, 48'h800000000000, 24'h800000,
               3, 2'b00, 8'h85, 48'h800000000000, 48'h040000000000, 1'b0);
      release_done("after_rst");

      lat = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
